uio_bus_arbiter: RTL and testbench

//  Shares the tile's 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) between N_REQ internal requesters.

---
 rtl/uio_bus_arbiter_pkg.sv | 19 +
 rtl/uio_rr_pick.sv | 39 +++
 rtl/uio_bus_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uio_bus_arbiter_pkg.sv
// Shared definitions for the uio pad bus arbiter and its round-robin picker.
package uio_bus_arbiter_pkg;

  // Arbiter FSM state codes; values are fixed so other tiles can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2
  } arb_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uio_rr_pick.sv
// Combinational round-robin picker: scans req starting at ptr and wrapping at
// N-1 -> 0, returning the first set requester as both one-hot and index.
module uio_rr_pick
  import uio_bus_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = cnt_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick_onehot,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_valid
);

  // Scan offsets from far to near so the requester closest to ptr wins last.
  always_comb begin : pick_scan
    int sum;
    logic [IDX_W-1:0] cand;
    sum         = 0;
    cand        = '0;
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      sum = int'(ptr) + off;
      if (sum >= N) begin
        sum = sum - N;
      end
      cand = IDX_W'(sum);
      if (req[cand]) begin
        pick_valid  = 1'b1;
        pick_idx    = cand;
        pick_onehot = N'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the tile's bidirectional uio pad bus between N_REQ internal engines.
// Round-robin ownership with a forced hi-Z turnaround before every new owner
// and a cap on how long one grant may hold the bus.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no owner, pads released, waiting for any request
//   TURN    | owner chosen, pads held hi-Z for TURNAROUND cycles
//   OWN     | owner granted; drives pads (dir=1) or is fed uio_in (dir=0)
module uio_bus_arbiter
  import uio_bus_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int W          = 8,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   last,
  input  logic [N_REQ-1:0]   dir,
  input  logic [N_REQ*W-1:0] dout,
  output logic [N_REQ-1:0]   grant,
  input  logic [W-1:0]       uio_in,
  output logic [W-1:0]       uio_out,
  output logic [W-1:0]       uio_oe,
  output logic [W-1:0]       rd_data,
  output logic               rd_valid
);

  localparam int IDX_W = cnt_width(N_REQ);
  localparam int TW    = cnt_width(TURNAROUND);
  localparam int HW    = cnt_width(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] own_oh_q, own_oh_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             own_dir_q, own_dir_d;

  logic [IDX_W-1:0] ptr_adv;
  logic [IDX_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             owner_req;
  logic             owner_last;
  logic             owner_dir;
  logic             hold_done;
  logic             release_own;
  logic             start_turn;
  logic [W-1:0]     drive_data;

  // Pointer one past the current owner; a releasing owner becomes lowest priority.
  always_comb begin
    if (owner_q == IDX_W'(N_REQ - 1)) begin
      ptr_adv = '0;
    end else begin
      ptr_adv = owner_q + IDX_W'(1);
    end
  end

  // On release the next pick already uses the advanced pointer.
  assign pick_ptr = (state_q == ST_OWN) ? ptr_adv : rr_ptr_q;

  uio_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req         (req),
    .ptr         (pick_ptr),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  assign owner_req   = req[owner_q];
  assign owner_last  = last[owner_q];
  assign owner_dir   = dir[owner_q];
  assign hold_done   = (hold_q == HW'(MAX_HOLD - 1));
  assign release_own = !owner_req || owner_last || hold_done || !ena;
  assign start_turn  = ena && pick_valid;

  // FSM state and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      own_oh_q  <= '0;
      rr_ptr_q  <= '0;
      tcnt_q    <= '0;
      hold_q    <= '0;
      own_dir_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      own_oh_q  <= own_oh_d;
      rr_ptr_q  <= rr_ptr_d;
      tcnt_q    <= tcnt_d;
      hold_q    <= hold_d;
      own_dir_q <= own_dir_d;
    end
  end

  // Next-state logic: arbitration, turnaround countdown, ownership release.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    own_oh_d  = own_oh_q;
    rr_ptr_d  = rr_ptr_q;
    tcnt_d    = tcnt_q;
    hold_d    = hold_q;
    own_dir_d = own_dir_q;

    case (state_q)
      ST_IDLE: begin
        if (start_turn) begin
          owner_d  = pick_idx;
          own_oh_d = pick_onehot;
          tcnt_d   = TW'(TURNAROUND - 1);
          state_d  = ST_TURN;
        end
      end

      ST_TURN: begin
        if (!ena) begin
          state_d = ST_IDLE;
        end else if (tcnt_q == '0) begin
          if (owner_req) begin
            // Direction is frozen for the whole ownership.
            own_dir_d = owner_dir;
            hold_d    = '0;
            state_d   = ST_OWN;
          end else begin
            // Requester went away during turnaround; pointer stays put.
            state_d = ST_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q - TW'(1);
        end
      end

      ST_OWN: begin
        if (release_own) begin
          rr_ptr_d = ptr_adv;
          if (start_turn) begin
            owner_d  = pick_idx;
            own_oh_d = pick_onehot;
            tcnt_d   = TW'(TURNAROUND - 1);
            state_d  = ST_TURN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Owner's drive data, selected by the registered owner index.
  always_comb begin
    drive_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        drive_data = dout[k*W +: W];
      end
    end
  end

  // Pad-facing outputs decode only from registered state.
  always_comb begin
    grant   = '0;
    uio_oe  = '0;
    uio_out = '0;
    if (state_q == ST_OWN) begin
      grant = own_oh_q;
      if (own_dir_q) begin
        uio_oe  = '1;
        uio_out = drive_data;
      end
    end
  end

  // Capture the pad bus on every cycle of a read ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (state_q == ST_OWN && !own_dir_q) begin
      rd_data  <= uio_in;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_uio_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TA = 1;
  localparam int MH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic [N-1:0]   req;
  logic [N-1:0]   last;
  logic [N-1:0]   dir;
  logic [N*W-1:0] dout;
  logic [N-1:0]   grant;
  logic [W-1:0]   uio_in;
  logic [W-1:0]   uio_out;
  logic [W-1:0]   uio_oe;
  logic [W-1:0]   rd_data;
  logic           rd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who holds (or is about to hold) the bus, and for how long.
  int         m_owner     = -1;
  bit         m_owning    = 1'b0;
  int         m_turn_left = 0;
  int         m_ptr       = 0;
  int         m_beats     = 0;
  bit         m_dir       = 1'b0;
  logic [W-1:0] m_rd      = '0;
  bit         m_rdv       = 1'b0;

  uio_bus_arbiter #(
    .N_REQ      (N),
    .W          (W),
    .TURNAROUND (TA),
    .MAX_HOLD   (MH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .req      (req),
    .last     (last),
    .dir      (dir),
    .dout     (dout),
    .grant    (grant),
    .uio_in   (uio_in),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int off = 0; off < N; off++) begin
      if (r[(p + off) % N]) begin
        return (p + off) % N;
      end
    end
    return -1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_owning = 0; m_turn_left = 0; m_ptr = 0;
      m_beats = 0; m_dir = 0; m_rd = '0; m_rdv = 0;
      return;
    end
    m_rdv = 0;
    if (m_owning && !m_dir) begin
      m_rd  = uio_in;
      m_rdv = 1;
    end
    if (m_owning) begin
      if (!req[m_owner] || last[m_owner] || m_beats == MH - 1 || !ena) begin
        m_owning = 0;
        m_ptr    = (m_owner + 1) % N;
        if (ena && req != 0) begin
          m_owner     = model_pick(req, m_ptr);
          m_turn_left = TA;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_beats++;
      end
    end else if (m_owner >= 0) begin
      if (!ena) begin
        m_owner = -1;
      end else begin
        m_turn_left--;
        if (m_turn_left == 0) begin
          if (req[m_owner]) begin
            m_owning = 1;
            m_dir    = dir[m_owner];
            m_beats  = 0;
          end else begin
            m_owner = -1;
          end
        end
      end
    end else if (ena && req != 0) begin
      m_owner     = model_pick(req, m_ptr);
      m_turn_left = TA;
    end
  endtask

  // Inputs are already applied (just after a falling edge); check, advance model, wait a cycle.
  task automatic run_cycle(input bit do_chk);
    logic [N-1:0] eg;
    logic [W-1:0] eoe;
    logic [W-1:0] eout;
    #1;
    if (do_chk) begin
      eg   = m_owning ? N'(1 << m_owner) : '0;
      eoe  = (m_owning && m_dir) ? '1 : '0;
      eout = (m_owning && m_dir) ? dout[m_owner*W +: W] : '0;
      check_val("grant", 32'(grant), 32'(eg));
      check_val("uio_oe", 32'(uio_oe), 32'(eoe));
      check_val("uio_out", 32'(uio_out), 32'(eout));
      check_val("rd_data", 32'(rd_data), 32'(m_rd));
      check_val("rd_valid", 32'(rd_valid), 32'(m_rdv));
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1; ena = 1; req = '0; last = '0; dir = '0;
    run_cycle(1);
    rst = 0;
  endtask

  initial begin
    logic [N-1:0] prev_g;
    logic [N-1:0] g;
    logic [N-1:0] rr_seq[$];
    logic [N-1:0] exp_seq[5];
    int zeros;
    int hold_len;
    logic [N-1:0] after_hold;
    bit done;

    rst = 1; ena = 0; req = '0; last = '0; dir = '0; dout = '0; uio_in = '0;
    @(negedge clk);
    run_cycle(0);
    run_cycle(1);
    rst = 0;
    ena = 1;

    // Single write: requester 0 drives A5, last on its third beat.
    dout = 32'h0000_00A5;
    dir  = 4'b0001;
    done = 0;
    for (int i = 0; i < 10; i++) begin
      last = (!done && m_owning && m_beats == 2) ? 4'b0001 : 4'b0000;
      if (last != 0) done = 1;
      req = done ? 4'b0000 : 4'b0001;
      run_cycle(1);
    end
    last = '0;

    // Read: requester 2 samples 3C from the pads.
    req = 4'b0100; dir = 4'b0000; uio_in = 8'h3C;
    for (int i = 0; i < 6; i++) run_cycle(1);
    req = '0;
    for (int i = 0; i < 2; i++) run_cycle(1);

    // Round-robin: all request, each releases after two beats.
    reset_dut();
    req = 4'b1111; dir = 4'b1111; dout = 32'hD4C3_B2A1;
    prev_g = '0; zeros = 0;
    for (int i = 0; i < 20; i++) begin
      g = grant;
      if (g != 0 && g != prev_g) begin
        if (rr_seq.size() > 0) check_val("rr_gap", 32'(zeros), 32'd1);
        rr_seq.push_back(g);
        zeros = 0;
      end else if (g == 0) begin
        zeros++;
      end
      prev_g = g;
      last = (m_owning && m_beats == 1) ? N'(1 << m_owner) : '0;
      run_cycle(1);
    end
    last = '0; req = '0;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    check_val("rr_count", 32'(rr_seq.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < rr_seq.size(); i++) begin
      check_val("rr_order", 32'(rr_seq[i]), 32'(exp_seq[i]));
    end

    // Hold limit: requester 1 never finishes, requester 3 waits.
    reset_dut();
    req = 4'b1010; dir = 4'b0000; hold_len = 0; after_hold = '0;
    for (int i = 0; i < 30; i++) begin
      if (grant == 4'b0010) hold_len++;
      if (grant == 4'b1000 && after_hold == 0) after_hold = grant;
      uio_in = 8'($urandom);
      run_cycle(1);
    end
    check_val("hold_len", 32'(hold_len), 32'(MH));
    check_val("hold_next", 32'(after_hold), 32'h8);
    req = '0;
    run_cycle(1);
    run_cycle(1);

    // Abort by ena mid write ownership.
    reset_dut();
    req = 4'b0001; dir = 4'b0001; dout = 32'h0000_005A;
    for (int i = 0; i < 10 && !(m_owning && m_beats == 1); i++) run_cycle(1);
    ena = 0;
    run_cycle(1);
    check_val("ena_abort_oe", 32'(uio_oe), 32'h0);
    check_val("ena_abort_grant", 32'(grant), 32'h0);
    ena = 1; req = '0;
    run_cycle(1);

    // Reset mid write ownership of requester 2; afterwards pointer restarts at 0.
    req = 4'b0100; dir = 4'b0100; dout = 32'h0077_0000;
    for (int i = 0; i < 10 && !(m_owning && m_beats == 1); i++) run_cycle(1);
    rst = 1;
    run_cycle(1);
    rst = 0; req = 4'b1111;
    for (int i = 0; i < 3; i++) run_cycle(1);
    check_val("rst_ptr_grant", 32'(grant), 32'h1);
    req = '0;
    run_cycle(1);
    run_cycle(1);

    // Abandoned grant: one-cycle pulse from requester 0.
    reset_dut();
    req = 4'b0001;
    run_cycle(1);
    req = '0;
    for (int i = 0; i < 3; i++) run_cycle(1);
    req = 4'b0011; dir = 4'b0011;
    for (int i = 0; i < 3; i++) run_cycle(1);
    req = '0;
    run_cycle(1);
    run_cycle(1);

    // Random traffic with sticky requests.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(7) == 0) req[k] = ~req[k];
      end
      last = '0;
      if ($urandom_range(9) == 0) last = N'($urandom_range(15));
      dir    = N'($urandom);
      dout   = $urandom;
      uio_in = W'($urandom);
      ena    = ($urandom_range(29) != 0);
      rst    = ($urandom_range(199) == 0);
      run_cycle(1);
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
